// File: rtl/acpo_sa_readout.sv
// acpo_sa_readout: drains the pooled-feature data/address BRAMs once every pooling
// lane has reported end of frame, and streams {data, address, last} downstream.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pool_last_i               per-lane end-of-frame pulses
//   num_entries_i             entries per bank for this frame
//   enb_d_sa / addrb_d_sa     data BRAM read port ({bank, entry} address)
//   enb_a / addrb_a           address BRAM read port (mirrors the data port)
//   dob_d_sa / dob_a          BRAM read data, valid one cycle after enable
//   out_valid_o/out_ready_i   output stream handshake
//   out_data_o/out_addr_o/out_last_o  output stream payload
//   busy_o                    frame readout in progress
//   done_o                    one-cycle pulse when a frame completes
module acpo_sa_readout #(
    parameter int unsigned SRAM_DEPTH     = 1024,
    parameter int unsigned BAND_WIDTH     = 16,
    parameter int unsigned POOL_NUM       = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_OUT_WIDTH = 10,
    parameter int unsigned SKID_DEPTH     = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [POOL_NUM-1:0]                                 pool_last_i,
    input  logic [$clog2(SRAM_DEPTH):0]                         num_entries_i,
    output logic                                                enb_d_sa,
    output logic [$clog2(SRAM_DEPTH)+$clog2(BAND_WIDTH)-1:0]    addrb_d_sa,
    output logic                                                enb_a,
    output logic [$clog2(SRAM_DEPTH)+$clog2(BAND_WIDTH)-1:0]    addrb_a,
    input  logic [DATA_WIDTH-1:0]                               dob_d_sa,
    input  logic [ADDR_OUT_WIDTH-1:0]                           dob_a,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output logic [DATA_WIDTH-1:0]                               out_data_o,
    output logic [ADDR_OUT_WIDTH-1:0]                           out_addr_o,
    output logic                                                out_last_o,
    output logic                                                busy_o,
    output logic                                                done_o
);

    localparam int unsigned EW = $clog2(SRAM_DEPTH);
    localparam int unsigned BW = $clog2(BAND_WIDTH);
    localparam int unsigned NW = EW + 1;
    localparam int unsigned PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned OW = CW + 1;
    localparam int unsigned FW = DATA_WIDTH + ADDR_OUT_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [POOL_NUM-1:0] mask_q, mask_d;
    logic [NW-1:0]       n_q, n_d;
    logic [BW-1:0]       bank_q, bank_d;
    logic [EW-1:0]       entry_q, entry_d;
    logic                inflight_q, inflight_last_q;
    logic                zero_done_q, zero_done_d;

    logic [FW-1:0]       mem [SKID_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [FW-1:0]       head;

    logic                mask_all, pop, push, room, entry_end, last_addr;
    logic                issue, issue_last, done_drain;
    logic [OW-1:0]       occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mask_all  = &(mask_q | pool_last_i);
        pop       = out_valid_o && out_ready_i;
        push      = inflight_q;
        // Slots that will be committed once this cycle's pop has drained; a new read
        // may only be issued if its beat is guaranteed a FIFO slot on arrival.
        occ       = OW'(count_q) + OW'(inflight_q) - OW'(pop);
        room      = occ < OW'(SKID_DEPTH);
        entry_end = (NW'(entry_q) + NW'(1)) == n_q;
        last_addr = entry_end && (bank_q == BW'(BAND_WIDTH - 1));

        state_d     = state_q;
        mask_d      = mask_q;
        n_d         = n_q;
        bank_d      = bank_q;
        entry_d     = entry_q;
        zero_done_d = 1'b0;
        issue       = 1'b0;
        issue_last  = 1'b0;
        done_drain  = 1'b0;

        unique case (state_q)
            StIdle: begin
                mask_d = mask_q | pool_last_i;
                if (mask_all) begin
                    mask_d = '0;
                    if (num_entries_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        n_d     = num_entries_i;
                        bank_d  = '0;
                        entry_d = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (room) begin
                    issue      = 1'b1;
                    issue_last = last_addr;
                    if (entry_end) begin
                        entry_d = '0;
                        bank_d  = bank_q + BW'(1);
                    end else begin
                        entry_d = entry_q + EW'(1);
                    end
                    if (last_addr) state_d = StDrain;
                end
            end
            StDrain: begin
                if (count_q == '0 && !inflight_q) begin
                    done_drain = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            mask_q          <= '0;
            n_q             <= '0;
            bank_q          <= '0;
            entry_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            n_q             <= n_d;
            bank_q          <= bank_d;
            entry_q         <= entry_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            zero_done_q     <= zero_done_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage needs no reset: every output is gated by out_valid_o.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {dob_d_sa, dob_a, inflight_last_q};
    end

    always_comb begin
        head        = mem[rd_ptr_q];
        out_valid_o = count_q != '0;
        out_data_o  = out_valid_o ? head[FW-1 -: DATA_WIDTH] : '0;
        out_addr_o  = out_valid_o ? head[ADDR_OUT_WIDTH:1] : '0;
        out_last_o  = out_valid_o && head[0];
        enb_d_sa    = issue;
        enb_a       = issue;
        addrb_d_sa  = issue ? {bank_q, entry_q} : '0;
        addrb_a     = addrb_d_sa;
        busy_o      = state_q != StIdle;
        done_o      = zero_done_q || done_drain;
    end

endmodule

// File: doc/acpo_sa_readout.md
Name: acpo_sa_readout

Overview:
- Drains the pooled-feature data and address buffers once every pooling lane has signalled end of frame.
- Issues BRAM reads on the buffers' read ports: data via enb_d_sa/addrb_d_sa, address via enb_a/addrb_a.
- Re-times the 1-cycle-latency BRAM outputs through a small skid FIFO.
- Presents a valid/ready stream of {data, address, last} to the next layer's feeder.

Parameters:
- SRAM_DEPTH, 1024, entries per bank
- BAND_WIDTH, 16, number of banks (one per pooling lane)
- POOL_NUM, 16, number of pool_last inputs (equals BAND_WIDTH)
- DATA_WIDTH, 8, feature data width
- ADDR_OUT_WIDTH, 10, stored result-address width
- SKID_DEPTH, 2, output FIFO depth (minimum 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pool_last_i  in  POOL_NUM  per-lane end-of-frame pulse, 1 cycle each
- num_entries_i  in  $clog2(SRAM_DEPTH)+1  entries written per bank this frame; sampled on the RUN-entry cycle
- enb_d_sa  out  1  data BRAM read enable
- addrb_d_sa  out  $clog2(SRAM_DEPTH)+$clog2(BAND_WIDTH)  data read address {bank, entry}
- enb_a  out  1  address BRAM read enable, always equal to enb_d_sa
- addrb_a  out  same as addrb_d_sa  address read address, always equal to addrb_d_sa
- dob_d_sa  in  DATA_WIDTH  data BRAM output, valid 1 cycle after enb
- dob_a  in  ADDR_OUT_WIDTH  address BRAM output, valid 1 cycle after enb
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready
- out_data_o  out  DATA_WIDTH  feature value
- out_addr_o  out  ADDR_OUT_WIDTH  feature destination address
- out_last_o  out  1  final element of frame
- busy_o  out  1  high in RUN or DRAIN
- done_o  out  1  1-cycle pulse at frame completion

Behaviour:
- Reset: all outputs 0, state IDLE, lane mask cleared, FIFO empty, counters 0.
- IDLE:
  - OR pool_last_i into a sticky lane mask each cycle.
  - Once the mask is all ones (including the cycle the last bit arrives, evaluated next cycle), sample num_entries_i.
  - If num_entries_i==0: pulse done_o the next cycle, clear the mask, stay IDLE.
  - Otherwise go to RUN; bank=0, entry=0.
- RUN:
  - Read order is bank-major: bank 0 entries 0..N-1, then bank 1, ... up to bank BAND_WIDTH-1.
  - Address = bank*SRAM_DEPTH + entry.
  - Issue a read (enb_d_sa=enb_a=1) only when inflight+occupancy-pop_this_cycle < SKID_DEPTH. This guarantees no overflow and no dropped beats.
  - After issuing address {BAND_WIDTH-1, N-1}, go to DRAIN.
- Read pipeline:
  - Read issued in cycle t → dob valid in t+1 → written into FIFO at the end of t+1 → out_valid_o earliest in t+2.
  - A last flag travels with the read that carries the final address.
- DRAIN: no reads issued. When the FIFO is empty and no read is in flight, go IDLE, pulse done_o for 1 cycle, clear the mask.
- Stream rules:
  - A transfer occurs when out_valid_o && out_ready_i.
  - out_data_o, out_addr_o and out_last_o stay stable while valid && !ready.
  - out_valid_o never deasserts without a transfer.
- Throughput: with out_ready_i held high, one beat per cycle sustained after the initial 2-cycle latency.
- Total beats per frame = BAND_WIDTH*N. out_last_o is high on exactly the final beat only.
- pool_last_i pulses during RUN/DRAIN are ignored; they are not carried into the next frame.
- rst asserted mid-frame aborts immediately to the reset state, discards FIFO contents, and emits no done_o.
- N==SRAM_DEPTH is legal: the entry counter wraps to 0 and the bank counter increments. There is no address overflow into the next bank.

Test Plan:
- Pulse all 16 pool_last_i bits in one cycle, N=3, ready=1 → 48 beats in order (bank0 e0..e2, bank1 e0, ...); first out_valid 3 cycles after the pulse; out_last only on beat 48; done_o 1 cycle after the final transfer.
- Stagger the pool_last_i bits over 20 cycles, with lane 7 pulsing twice → RUN is entered only after the 16th distinct lane; addrb_d_sa stays 0 and enb stays 0 beforehand.
- N=2, out_ready_i toggling 1,0,0,1 repeating → exactly 32 beats; no duplicates or losses; outputs held stable during stalls; inflight+occupancy never exceeds 2.
- num_entries_i=0 → no enb asserted, no out_valid_o; done_o pulses once; busy_o stays 0.
- N=1024 with BRAM models preloaded with data=addr[7:0] → 16384 beats; read addresses run 0..16383 contiguous; data matches the model.
- Assert rst during RUN at beat 10 → all outputs 0 the next cycle; no done_o; a fresh frame afterwards starts at address 0.
